fetch_decode_unit: RTL and testbench
====================================

// Module: fetch_decode_unit
// PURPOSE
//  Producer side of the IQ_2_IR issue handshake.
//  Fetches RV32I instructions from the I-side memory port and decodes each one into a
//  tomasula_types::ctl_word. It then presents the word to the instruction queue with ld_iq
//  and holds it until ack. Sits between the I-cache and the instruction queue; the branch
//  unit redirects it via flush.
// PARAMETERS
//  RESET_PC  32'h00000060  fetch address loaded on reset
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous active-high reset
//  imem_read        out  1   I-mem read request, held until imem_resp
//  imem_address     out  32  I-mem word address (= pc)
//  imem_rdata       in   32  instruction data, valid with imem_resp
//  imem_resp        in   1   one-cycle response strobe
//  issue_q_full_n   in   1   IQ has space (informational; ack_i is authoritative)
//  ack_i            in   1   IQ accepted control_word this cycle
//  ld_iq            out  1   control_word valid, request enqueue
//  control_word     out  ctl_word  decoded instruction
//  flush_i          in   1   redirect (mispredict/jump), one-cycle strobe
//  flush_pc_i       in   32  redirect target, sampled with flush_i
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, cw register=all zero (op=BRANCH encoding 0).
//    During the rst cycle: imem_read=0, ld_iq=0, control_word=0.
//  All outputs decode from registered state; no combinational path from ack_i to ld_iq.
//  FETCH: imem_read=1, imem_address=pc.
//    On imem_resp: decode imem_rdata into cw.
//    Legal opcode -> ISSUE. Illegal -> pc+=4, stay FETCH, nothing issued.
//  ISSUE: ld_iq=1, control_word=cw, held stable until ack_i.
//    On ack_i: pc+=4 (no prediction), ->FETCH. ld_iq falls the next cycle.
//    Minimum 2 cycles per instr plus memory latency.
//  DRAIN: imem_read=1 at stale address until imem_resp; data discarded; ->FETCH.
//  flush_i (any state, priority over everything except rst): pc<=flush_pc_i.
//    FETCH w/o same-cycle resp -> DRAIN.
//    FETCH with resp -> FETCH (data dropped).
//    ISSUE -> FETCH (word dropped, even if ack_i same cycle; IQ flushes itself). DRAIN stays DRAIN.
//  Reset mid-fetch: outstanding response ignored only if it arrives in the rst cycle;
//    the I-cache is reset by the same rst.
//  pc arithmetic: 32-bit, wraps modulo 2^32, low 2 bits always 0.
//  Decode:
//    pc = fetch pc. funct3 = instr[14:12]. funct7 = instr[30].
//    srcN_valid=1 means operand comes from the regfile.
//   OP(0110011):     ALU,   src1=rs1 v, src2=rs2 v, src2_data=0, rd
//   OP-IMM(0010011): ALU,   src1=rs1 v, src2_valid=0, src2_data=sextI;
//                    funct7=instr[30] only if funct3==101, else 0
//   LOAD(0000011):   LOAD,  src1=rs1 v, src2_valid=0, src2_data=sextI, rd
//   STORE(0100011):  STORE, src1=rs1 v, src2=rs2 v, src2_data=sextS, rd=0
//   BRANCH(1100011): BRANCH, src1, src2 v, src2_data=sextB, rd=0
//   JAL(1101111):    JAL,  src1_valid=0, src2_valid=0, src2_data=sextJ, rd
//   JALR(1100111):   JALR, src1=rs1 v, src2_valid=0, src2_data=sextI, rd
//   LUI/AUIPC:       LUI/AUIPC, src1_valid=0, src2_valid=0, src2_data={instr[31:12],12'b0}, rd
//   Unused reg fields = 0. rd=x0 issued as-is.
// TESTING
//  1. Reset, imem returns 32'h00500093 (addi x1,x0,5) after 3 cycles
//     -> imem_address=0x60; ld_iq with op=ALU, src1_reg=0, src2_data=5, rd=1, pc=0x60.
//  2. Hold ack_i=0 for 10 cycles -> control_word stable, imem_read=0.
//     ack_i then -> next fetch at 0x64.
//  3. flush_i (flush_pc_i=0x200) while fetch outstanding -> DRAIN;
//     stale resp discarded, no ld_iq; next imem_address=0x200.
//  4. flush_i and ack_i same cycle in ISSUE -> ld_iq=0 next cycle, fetch 0x200, pc != old+4.
//  5. Illegal opcode 32'hFFFFFFFF at 0x64 -> no ld_iq; fetch 0x68.
//  6. Decode sweep: beq x1,x2,-8 -> BRANCH, src2_data=0xFFFFFFF8, rd=0;
//     sw x3,12(x4) -> STORE, src2_data=12;
//     srai x5,x6,3 -> funct7=1; lui -> src1_valid=0.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - RV32I fetch + decode, producer side of the instruction-queue issue handshake

package tomasula_types;

  typedef enum logic [2:0] {
    OP_BRANCH = 3'd0,
    OP_ALU    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_JAL    = 3'd4,
    OP_JALR   = 3'd5,
    OP_LUI    = 3'd6,
    OP_AUIPC  = 3'd7
  } op_t;

  // srcN_valid=1 means the operand is read from the register file.
  typedef struct packed {
    op_t         op;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic        funct7;
    logic [4:0]  src1_reg;
    logic        src1_valid;
    logic [4:0]  src2_reg;
    logic        src2_valid;
    logic [31:0] src2_data;
    logic [4:0]  rd;
  } ctl_word;

endpackage

module fetch_decode_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_read,
  output logic [31:0]            imem_address,
  input  logic [31:0]            imem_rdata,
  input  logic                   imem_resp,
  input  logic                   issue_q_full_n,
  input  logic                   ack_i,
  output logic                   ld_iq,
  output tomasula_types::ctl_word control_word,
  input  logic                   flush_i,
  input  logic [31:0]            flush_pc_i
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [31:0]             drain_addr_q, drain_addr_d;
  tomasula_types::ctl_word cw_q, cw_d;
  tomasula_types::ctl_word dec_cw;
  logic                    dec_legal;
  logic [31:0]             pc_plus4;

  // ack_i is the authoritative acceptance signal; the full flag and the
  // redirect low bits (always forced to word alignment) are not consulted.
  logic unused_inputs;
  assign unused_inputs = issue_q_full_n ^ flush_pc_i[1] ^ flush_pc_i[0];

  assign pc_plus4 = pc_q + 32'd4;

  // Decode the returned instruction word into a control word for the queue
  always_comb begin
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rdf;
    logic [2:0]  f3;
    instr = imem_rdata;
    rs1   = instr[19:15];
    rs2   = instr[24:20];
    rdf   = instr[11:7];
    f3    = instr[14:12];
    dec_cw    = '0;
    dec_cw.pc = pc_q;
    dec_legal = 1'b1;
    case (instr[6:0])
      7'b0110011: begin
        dec_cw.op         = tomasula_types::OP_ALU;
        dec_cw.funct3     = f3;
        dec_cw.funct7     = instr[30];
        dec_cw.src1_reg   = rs1;
        dec_cw.src1_valid = 1'b1;
        dec_cw.src2_reg   = rs2;
        dec_cw.src2_valid = 1'b1;
        dec_cw.rd         = rdf;
      end
      7'b0010011: begin
        dec_cw.op         = tomasula_types::OP_ALU;
        dec_cw.funct3     = f3;
        // Only the shift-right group uses instr[30] to pick arithmetic vs logical.
        dec_cw.funct7     = (f3 == 3'b101) ? instr[30] : 1'b0;
        dec_cw.src1_reg   = rs1;
        dec_cw.src1_valid = 1'b1;
        dec_cw.src2_data  = {{20{instr[31]}}, instr[31:20]};
        dec_cw.rd         = rdf;
      end
      7'b0000011: begin
        dec_cw.op         = tomasula_types::OP_LOAD;
        dec_cw.funct3     = f3;
        dec_cw.src1_reg   = rs1;
        dec_cw.src1_valid = 1'b1;
        dec_cw.src2_data  = {{20{instr[31]}}, instr[31:20]};
        dec_cw.rd         = rdf;
      end
      7'b0100011: begin
        dec_cw.op         = tomasula_types::OP_STORE;
        dec_cw.funct3     = f3;
        dec_cw.src1_reg   = rs1;
        dec_cw.src1_valid = 1'b1;
        dec_cw.src2_reg   = rs2;
        dec_cw.src2_valid = 1'b1;
        dec_cw.src2_data  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        dec_cw.op         = tomasula_types::OP_BRANCH;
        dec_cw.funct3     = f3;
        dec_cw.src1_reg   = rs1;
        dec_cw.src1_valid = 1'b1;
        dec_cw.src2_reg   = rs2;
        dec_cw.src2_valid = 1'b1;
        dec_cw.src2_data  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b1101111: begin
        dec_cw.op        = tomasula_types::OP_JAL;
        dec_cw.src2_data = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec_cw.rd        = rdf;
      end
      7'b1100111: begin
        dec_cw.op         = tomasula_types::OP_JALR;
        dec_cw.funct3     = f3;
        dec_cw.src1_reg   = rs1;
        dec_cw.src1_valid = 1'b1;
        dec_cw.src2_data  = {{20{instr[31]}}, instr[31:20]};
        dec_cw.rd         = rdf;
      end
      7'b0110111: begin
        dec_cw.op        = tomasula_types::OP_LUI;
        dec_cw.src2_data = {instr[31:12], 12'b0};
        dec_cw.rd        = rdf;
      end
      7'b0010111: begin
        dec_cw.op        = tomasula_types::OP_AUIPC;
        dec_cw.src2_data = {instr[31:12], 12'b0};
        dec_cw.rd        = rdf;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // State, pc, drain address and control-word registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      cw_q         <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      cw_q         <= cw_d;
    end
  end

  // Next-state logic; a redirect overrides the normal handshake flow
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      case (state_q)
        S_FETCH: state_d = imem_resp ? S_FETCH : S_DRAIN;
        S_ISSUE: state_d = S_FETCH;
        default: state_d = S_DRAIN;
      endcase
    end else begin
      case (state_q)
        S_FETCH: if (imem_resp && dec_legal) state_d = S_ISSUE;
        S_ISSUE: if (ack_i) state_d = S_FETCH;
        S_DRAIN: if (imem_resp) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Datapath next values: pc advance, redirect, decoded word capture
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    cw_d         = cw_q;
    if (flush_i) begin
      pc_d = {flush_pc_i[31:2], 2'b00};
      // The outstanding request keeps its original address while it drains.
      if (state_q == S_FETCH && !imem_resp) drain_addr_d = pc_q;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_resp) begin
            if (dec_legal) cw_d = dec_cw;
            else           pc_d = pc_plus4;
          end
        end
        S_ISSUE: if (ack_i) pc_d = pc_plus4;
        default: ;
      endcase
    end
  end

  // Outputs from registered state only; rst forces the request/valid lines low
  always_comb begin
    imem_read    = !rst && (state_q == S_FETCH || state_q == S_DRAIN);
    imem_address = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    ld_iq        = !rst && (state_q == S_ISSUE);
    control_word = rst ? '0 : cw_q;
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - directed self-checking bench for fetch_decode_unit

module tb_fetch_decode_unit;
  import tomasula_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        issue_q_full_n;
  logic        ack_i;
  logic        ld_iq;
  ctl_word     control_word;
  logic        flush_i;
  logic [31:0] flush_pc_i;

  int checks = 0;
  int failures = 0;

  fetch_decode_unit #(.RESET_PC(32'h0000_0060)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .issue_q_full_n (issue_q_full_n),
    .ack_i          (ack_i),
    .ld_iq          (ld_iq),
    .control_word   (control_word),
    .flush_i        (flush_i),
    .flush_pc_i     (flush_pc_i)
  );

  always #5 clk = ~clk;

  function automatic ctl_word mk(input op_t op, input logic [31:0] pc, input logic [2:0] f3,
                                 input logic f7, input logic [4:0] s1, input logic s1v,
                                 input logic [4:0] s2, input logic s2v, input logic [31:0] data,
                                 input logic [4:0] rd);
    ctl_word c;
    c.op = op; c.pc = pc; c.funct3 = f3; c.funct7 = f7;
    c.src1_reg = s1; c.src1_valid = s1v; c.src2_reg = s2; c.src2_valid = s2v;
    c.src2_data = data; c.rd = rd;
    return c;
  endfunction

  task automatic wait_ld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ld_iq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic fetch_issue(input logic [31:0] instr, input int lat, output bit ok);
    repeat (lat) @(negedge clk);
    imem_rdata = instr;
    imem_resp  = 1'b1;
    @(negedge clk);
    imem_resp  = 1'b0;
    wait_ld(ok);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    imem_resp = 1'b1;
    imem_rdata = 32'h0050_0093;
    @(negedge clk);
    checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL reset_imem_read got=%b exp=0", imem_read); end
    checks++; if (ld_iq !== 1'b0) begin failures++; $display("FAIL reset_ld_iq got=%b exp=0", ld_iq); end
    checks++; if (control_word !== '0) begin failures++; $display("FAIL reset_cw got=%h exp=0", control_word); end
    rst = 1'b0;
    imem_resp = 1'b0;
    @(negedge clk);
    checks++; if (imem_read !== 1'b1) begin failures++; $display("FAIL post_reset_read got=%b exp=1", imem_read); end
    checks++; if (imem_address !== 32'h60) begin failures++; $display("FAIL post_reset_addr got=%h exp=00000060", imem_address); end
    checks++; if (ld_iq !== 1'b0) begin failures++; $display("FAIL post_reset_ld_iq got=%b exp=0", ld_iq); end
  endtask

  task automatic test_first_issue;
    bit ok;
    ctl_word exp;
    exp = mk(OP_ALU, 32'h60, 3'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 32'd5, 5'd1);
    fetch_issue(32'h0050_0093, 2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL first_issue_timeout got=ld_iq_low exp=ld_iq_high"); end
    checks++; if (control_word !== exp) begin failures++; $display("FAIL first_issue_cw got=%h exp=%h", control_word, exp); end
  endtask

  task automatic test_hold;
    ctl_word exp;
    exp = mk(OP_ALU, 32'h60, 3'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 32'd5, 5'd1);
    ack_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (control_word !== exp || ld_iq !== 1'b1 || imem_read !== 1'b0) begin
        failures++; $display("FAIL hold_stable cycle=%0d got cw=%h ld=%b rd=%b exp cw=%h ld=1 rd=0", i, control_word, ld_iq, imem_read, exp);
      end
    end
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    checks++; if (ld_iq !== 1'b0) begin failures++; $display("FAIL ack_ld_iq_fall got=%b exp=0", ld_iq); end
    checks++; if (imem_read !== 1'b1 || imem_address !== 32'h64) begin
      failures++; $display("FAIL ack_next_fetch got rd=%b addr=%h exp rd=1 addr=00000064", imem_read, imem_address);
    end
  endtask

  task automatic test_flush_drain;
    flush_i = 1'b1;
    flush_pc_i = 32'h200;
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (imem_read !== 1'b1 || imem_address !== 32'h64 || ld_iq !== 1'b0) begin
      failures++; $display("FAIL drain_stale got rd=%b addr=%h ld=%b exp rd=1 addr=00000064 ld=0", imem_read, imem_address, ld_iq);
    end
    @(negedge clk);
    imem_rdata = 32'h0050_0093;
    imem_resp = 1'b1;
    @(negedge clk);
    imem_resp = 1'b0;
    checks++; if (ld_iq !== 1'b0) begin failures++; $display("FAIL drain_discard got ld=%b exp=0", ld_iq); end
    checks++; if (imem_read !== 1'b1 || imem_address !== 32'h200) begin
      failures++; $display("FAIL drain_refetch got rd=%b addr=%h exp rd=1 addr=00000200", imem_read, imem_address);
    end
  endtask

  task automatic test_flush_ack;
    bit ok;
    ctl_word exp;
    exp = mk(OP_ALU, 32'h200, 3'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 32'd7, 5'd2);
    fetch_issue(32'h0070_0113, 1, ok);
    checks++; if (!ok || control_word !== exp) begin
      failures++; $display("FAIL flush_ack_issue got ok=%b cw=%h exp ok=1 cw=%h", ok, control_word, exp);
    end
    ack_i = 1'b1;
    flush_i = 1'b1;
    flush_pc_i = 32'h200;
    @(negedge clk);
    ack_i = 1'b0;
    flush_i = 1'b0;
    checks++; if (ld_iq !== 1'b0) begin failures++; $display("FAIL flush_ack_ld got=%b exp=0", ld_iq); end
    checks++; if (imem_address !== 32'h200 || imem_read !== 1'b1) begin
      failures++; $display("FAIL flush_ack_addr got rd=%b addr=%h exp rd=1 addr=00000200", imem_read, imem_address);
    end
  endtask

  task automatic test_illegal;
    flush_i = 1'b1;
    flush_pc_i = 32'h64;
    imem_rdata = 32'h0050_0093;
    imem_resp = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    imem_resp = 1'b0;
    checks++; if (ld_iq !== 1'b0 || imem_read !== 1'b1 || imem_address !== 32'h64) begin
      failures++; $display("FAIL flush_with_resp got ld=%b rd=%b addr=%h exp ld=0 rd=1 addr=00000064", ld_iq, imem_read, imem_address);
    end
    imem_rdata = 32'hFFFF_FFFF;
    imem_resp = 1'b1;
    @(negedge clk);
    imem_resp = 1'b0;
    checks++; if (ld_iq !== 1'b0) begin failures++; $display("FAIL illegal_no_issue got=%b exp=0", ld_iq); end
    checks++; if (imem_address !== 32'h68 || imem_read !== 1'b1) begin
      failures++; $display("FAIL illegal_advance got rd=%b addr=%h exp rd=1 addr=00000068", imem_read, imem_address);
    end
  endtask

  task automatic test_decode_sweep;
    logic [31:0] instr [6];
    ctl_word     exp   [6];
    bit          ok;
    logic [31:0] pc;
    instr[0] = 32'hFE20_8CE3;
    exp[0]   = mk(OP_BRANCH, 32'h68, 3'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 32'hFFFF_FFF8, 5'd0);
    instr[1] = 32'h0032_2623;
    exp[1]   = mk(OP_STORE, 32'h6C, 3'd2, 1'b0, 5'd4, 1'b1, 5'd3, 1'b1, 32'd12, 5'd0);
    instr[2] = 32'h4033_5293;
    exp[2]   = mk(OP_ALU, 32'h70, 3'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 32'h0000_0403, 5'd5);
    instr[3] = 32'h1234_53B7;
    exp[3]   = mk(OP_LUI, 32'h74, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h1234_5000, 5'd7);
    instr[4] = 32'h0100_00EF;
    exp[4]   = mk(OP_JAL, 32'h78, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd16, 5'd1);
    instr[5] = 32'hFFC4_A403;
    exp[5]   = mk(OP_LOAD, 32'h7C, 3'd2, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 32'hFFFF_FFFC, 5'd8);
    pc = 32'h68;
    for (int i = 0; i < 6; i++) begin
      fetch_issue(instr[i], 1, ok);
      checks++; if (!ok || control_word !== exp[i]) begin
        failures++; $display("FAIL decode_%0d got ok=%b cw=%h exp ok=1 cw=%h", i, ok, control_word, exp[i]);
      end
      ack_i = 1'b1;
      @(negedge clk);
      ack_i = 1'b0;
      pc = pc + 32'd4;
      checks++; if (ld_iq !== 1'b0 || imem_address !== pc) begin
        failures++; $display("FAIL decode_next_%0d got ld=%b addr=%h exp ld=0 addr=%h", i, ld_iq, imem_address, pc);
      end
    end
  endtask

  task automatic test_pc_wrap;
    flush_i = 1'b1;
    flush_pc_i = 32'hFFFF_FFFE;
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (imem_address !== 32'h80) begin failures++; $display("FAIL wrap_drain_addr got=%h exp=00000080", imem_address); end
    imem_rdata = 32'h0050_0093;
    imem_resp = 1'b1;
    @(negedge clk);
    checks++; if (imem_address !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_align got=%h exp=fffffffc", imem_address); end
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_resp = 1'b0;
    checks++; if (imem_address !== 32'h0 || ld_iq !== 1'b0) begin
      failures++; $display("FAIL wrap_modulo got addr=%h ld=%b exp addr=00000000 ld=0", imem_address, ld_iq);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_rdata = '0;
    imem_resp = 1'b0;
    issue_q_full_n = 1'b1;
    ack_i = 1'b0;
    flush_i = 1'b0;
    flush_pc_i = '0;
    test_reset();
    test_first_issue();
    test_hold();
    test_flush_drain();
    test_flush_ack();
    test_illegal();
    test_decode_sweep();
    test_pc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
